uart_tx_serializer: RTL and testbench

//   Datapath partner of the UART TX controller FSM: latches the parallel byte, shifts it out LSB-first one bit per ser_en cycle.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_parity_calc.sv | 26 ++
 rtl/uart_tx_serializer.sv | 77 +++++++
 tb/tb_uart_tx_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX datapath and controller:
// default frame width, parity type encodings and TX output mux select codes.
package uart_tx_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        MUX_START  = 2'b00,
        MUX_STOP   = 2'b01,
        MUX_DATA   = 2'b10,
        MUX_PARITY = 2'b11
    } tx_mux_sel_e;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Registered parity of the word being loaded into the serializer.
// The value is taken from the parallel input at load time, so it stays stable
// while the shift register empties.
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    input  logic                  load,
    output logic                  par_bit
);

    // capture even/odd parity of the incoming word on load, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (load) begin
            par_bit <= (par_typ == PAR_ODD) ? ~^data : ^data;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: latches a parallel word when the controller is free and
// shifts it out LSB first, one bit per ser_en cycle after a start-bit cycle.
// ser_done flags the last data bit to the controller.
// Build option: UART_TX_SER_PARITY_EN enables the registered parity bit;
// without it par_bit is tied low and par_typ is ignored.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  free,
    input  logic                  ser_en,
    input  logic                  par_typ,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  par_bit
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic                  load;

    assign load = data_valid && free;

    // cnt 0 is the start-bit cycle; data bits are presented at cnt 1..DATA_WIDTH.
    // The shift happens after bits 0..DATA_WIDTH-2, so the MSB sits in shreg[0]
    // for the final cycle. Dropping ser_en rewinds to the start-bit cycle but
    // keeps whatever bits remain in shreg.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= p_data;
            cnt   <= '0;
        end else if (ser_en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
                if (cnt != '0) begin
                    shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
                end
            end
        end else begin
            cnt <= '0;
        end
    end

    assign ser_data = shreg[0];
    assign ser_done = ser_en && (cnt == CNT_LAST);

`ifdef UART_TX_SER_PARITY_EN
    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .clk     (clk),
        .rst     (rst),
        .data    (p_data),
        .par_typ (par_typ),
        .load    (load),
        .par_bit (par_bit)
    );
`else
    logic unused_par_typ;
    assign unused_par_typ = par_typ;
    assign par_bit        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: directed frames with hand-computed bit and
// parity expectations, checked through an expected-response queue by a
// separate negedge monitor.
module tb_uart_tx_serializer;

    localparam int DW = 8;

`ifdef UART_TX_SER_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          free;
    logic          ser_en;
    logic          par_typ;
    logic          ser_data;
    logic          ser_done;
    logic          par_bit;

    typedef struct {
        logic [2:0] val;   // {ser_data, ser_done, par_bit}
        logic [2:0] mask;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .free       (free),
        .ser_en     (ser_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .par_bit    (par_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: every cycle that has an expectation queued is compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t       e;
            logic [2:0] got;
            e   = exp_q.pop_front();
            got = {ser_data, ser_done, par_bit};
            n_tests++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got {data,done,par}=%b required %b (mask %b)",
                         e.name, got, e.val, e.mask);
            end
        end
    end

    // one clock of stimulus; optionally queue the response expected this cycle
    task automatic cyc(input logic r, input logic dv, input logic fr, input logic se,
                       input logic pt, input logic [DW-1:0] pd,
                       input logic [2:0] mask, input logic [2:0] val, input string name);
        @(posedge clk);
        #1;
        rst        = r;
        data_valid = dv;
        free       = fr;
        ser_en     = se;
        par_typ    = pt;
        p_data     = pd;
        if (mask != 3'b000) begin
            exp_t e;
            e.val  = val;
            e.mask = mask;
            e.name = name;
            exp_q.push_back(e);
        end
    endtask

    // 1+DW ser_en cycles of an already loaded word; noise drives a competing word while busy
    task automatic run_frame(input logic [DW-1:0] data, input logic par_hand,
                             input logic noise, input string name);
        for (int k = 0; k <= DW; k++) begin
            logic sd;
            sd = (k == 0) ? data[0] : data[k-1];
            cyc(1'b0, noise, 1'b0, 1'b1, 1'b0, noise ? 8'hFF : data, 3'b111,
                {sd, (k == DW), PAR_ON & par_hand}, $sformatf("%s_k%0d", name, k));
        end
    endtask

    // load cycle (doubles as the stop cycle of a previous frame) then the frame
    task automatic frame(input logic [DW-1:0] data, input logic pt, input logic par_hand,
                         input logic noise, input string name);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, pt, data, 3'b010, 3'b000, {name, "_load"});
        run_frame(data, par_hand, noise, name);
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b1;
        free       = 1'b1;
        ser_en     = 1'b0;
        par_typ    = 1'b0;
        p_data     = 8'hFF;

        // reset held with a valid word presented: nothing is captured
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 3'b111, 3'b000, "rst_c1");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 3'b111, 3'b000, "rst_c2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b111, 3'b000, "rst_no_load");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b000, "rst_empty_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000, "idle");

        // basic frame A5, even parity (four ones -> 0)
        frame(8'hA5, 1'b0, 1'b0, 1'b0, "a5");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b010, 3'b000, "a5_stop");

        // parity selection
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 3'b000, 3'b000, "ld01");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b011, {2'b00, PAR_ON & 1'b0}, "par_01_odd");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 3'b000, 3'b000, "ld03o");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b011, {2'b00, PAR_ON & 1'b1}, "par_03_odd");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 3'b000, 3'b000, "ld03e");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'b011, {2'b00, PAR_ON & 1'b0}, "par_03_even");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 3'b000, 3'b000, "ld80o");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b011, {2'b00, PAR_ON & 1'b0}, "par_80_odd");

        // competing word while not free is ignored
        frame(8'hA5, 1'b0, 1'b0, 1'b1, "a5_busy");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000, "idle");

        // reset while presenting data bit 4 of C3 (bit4 = 0)
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 3'b010, 3'b000, "c3_load");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b100, "c3_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b100, "c3_b0");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b100, "c3_b1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b000, "c3_b2");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b000, "c3_b3");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b000, "c3_b4_rst");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b000, "c3_after_rst0");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b000, "c3_after_rst1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b000, "c3_after_rst2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b111, 3'b000, "c3_idle");
        frame(8'h5A, 1'b0, 1'b0, 1'b0, "5a");

        // load colliding with ser_en mid-frame: the new word restarts the frame
        frame(8'h69, 1'b0, 1'b0, 1'b0, "69");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h69, 3'b010, 3'b000, "69b_load");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b100, "69b_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111, 3'b100, "69b_b0");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h96, 3'b000, 3'b000, "collide");
        run_frame(8'h96, 1'b1, 1'b0, "96_odd");

        // back-to-back frames: second load happens in the stop cycle after ser_done
        frame(8'h3C, 1'b0, 1'b0, 1'b0, "3c");
        frame(8'hE7, 1'b1, 1'b1, 1'b0, "e7_odd");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b011, {2'b00, PAR_ON & 1'b1}, "e7_stop");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
